shift_register_sequencer: RTL and testbench

- Controller that shares one WIDTH-bit right-shift register between two requesters and sequences it through a load followed by SHIFT_COUNT shifts.
- Drives the register's load, shift and data_in pins, and reads its data_out.
- Returns the shifted-out LSB stream as a serial bit with a valid strobe.
- Sits between client logic and the shift-register datapath; arbitration is round-robin.

---
 rtl/shift_register_sequencer.sv | 127 ++++++++++++
 tb/tb_shift_register_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_sequencer.sv
// Round-robin sequencer sharing one right-shift register between two clients.
// Each grant loads the winner's word, then streams SHIFT_COUNT bits LSB first.
module shift_register_sequencer #(
  parameter int WIDTH       = 4,
  parameter int SHIFT_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sr_load,
  output logic             sr_shift,
  output logic [WIDTH-1:0] sr_data_in,
  input  logic [WIDTH-1:0] sr_data_out,
  output logic             ser_bit,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic             done_id
);

  localparam int CW = (SHIFT_COUNT < 2) ? 1 : $clog2(SHIFT_COUNT);
  localparam logic [CW-1:0] LAST = CW'(SHIFT_COUNT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_id;
  logic             r_last;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_load;
  logic             r_shift;
  logic [WIDTH-1:0] r_din;
  logic             r_ser;
  logic             r_bv;
  logic             r_busy;
  logic             r_done;
  logic             r_done_id;

  logic w_pick1;
  logic w_unused;

  // On a tie, serve whoever was not served last.
  assign w_pick1  = req1 & (~req0 | ~r_last);
  assign w_unused = ^sr_data_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_id      <= 1'b0;
      r_last    <= 1'b1;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_load    <= 1'b0;
      r_shift   <= 1'b0;
      r_din     <= '0;
      r_ser     <= 1'b0;
      r_bv      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_load <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req0 | req1) begin
            r_state <= S_LOAD;
            r_gnt0  <= ~w_pick1;
            r_gnt1  <= w_pick1;
            r_load  <= 1'b1;
            r_din   <= w_pick1 ? data1 : data0;
            r_busy  <= 1'b1;
            r_id    <= w_pick1;
          end
        end
        S_LOAD: begin
          r_shift <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_ser <= sr_data_out[0];
          r_bv  <= 1'b1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_shift   <= 1'b0;
            r_done    <= 1'b1;
            r_done_id <= r_id;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_bv    <= 1'b0;
          r_busy  <= 1'b0;
          r_last  <= r_id;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt0       = r_gnt0;
  assign gnt1       = r_gnt1;
  assign sr_load    = r_load;
  assign sr_shift   = r_shift;
  assign sr_data_in = r_din;
  assign ser_bit    = r_ser;
  assign bit_valid  = r_bv;
  assign busy       = r_busy;
  assign done       = r_done;
  assign done_id    = r_done_id;

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Bench for shift_register_sequencer: random and directed traffic,
// expected transactions queued at issue and matched by a monitor.
module tb_shift_register_sequencer;

  localparam int W = 4;

  typedef struct {
    bit           id;
    logic [W-1:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] data0, data1;
  logic         gnt0, gnt1;
  logic         sr_load, sr_shift;
  logic [W-1:0] sr_data_in;
  logic [W-1:0] sr_data_out;
  logic         ser_bit, bit_valid, busy, done, done_id;

  logic         b_req0, b_req1;
  logic [W-1:0] b_data0, b_data1;
  logic         b_gnt0, b_gnt1;
  logic         b_load, b_shift;
  logic [W-1:0] b_din;
  logic [W-1:0] b_dout;
  logic         b_ser, b_bv, b_busy, b_done, b_done_id;

  logic [W-1:0] sreg  = '0;
  logic [W-1:0] sreg2 = '0;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  bit   hold0, hold1, mlast;

  exp_t         cur;
  bit           act;
  bit           post_done;
  int           nsh, nb;
  logic [W-1:0] bits;

  int           ns2, nb2;
  bit           seen2;
  logic [1:0]   bb2;

  shift_register_sequencer #(.WIDTH(W), .SHIFT_COUNT(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1),
    .sr_load(sr_load), .sr_shift(sr_shift),
    .sr_data_in(sr_data_in), .sr_data_out(sr_data_out),
    .ser_bit(ser_bit), .bit_valid(bit_valid),
    .busy(busy), .done(done), .done_id(done_id)
  );

  shift_register_sequencer #(.WIDTH(W), .SHIFT_COUNT(2)) dut2 (
    .clk(clk), .rst(rst),
    .req0(b_req0), .data0(b_data0), .req1(b_req1), .data1(b_data1),
    .gnt0(b_gnt0), .gnt1(b_gnt1),
    .sr_load(b_load), .sr_shift(b_shift),
    .sr_data_in(b_din), .sr_data_out(b_dout),
    .ser_bit(b_ser), .bit_valid(b_bv),
    .busy(b_busy), .done(b_done), .done_id(b_done_id)
  );

  always #5 clk = ~clk;

  // Register models with random fill bits; only bit 0 should matter.
  assign sr_data_out = sreg;
  assign b_dout      = sreg2;

  always @(posedge clk) begin
    if (sr_load) sreg <= sr_data_in;
    else if (sr_shift) sreg <= {1'($urandom_range(0, 1)), sreg[W-1:1]};
    if (b_load) sreg2 <= b_din;
    else if (b_shift) sreg2 <= {1'($urandom_range(0, 1)), sreg2[W-1:1]};
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  // Reference arbitration: single requester wins, tie goes to the one not last served.
  task automatic start_txn(input bit r0, input bit r1,
                           input logic [W-1:0] v0, input logic [W-1:0] v1);
    bit   w;
    exp_t e;
    req0  = r0;
    req1  = r1;
    data0 = v0;
    data1 = v1;
    w     = (r0 && r1) ? ~mlast : r1;
    mlast = w;
    e.id   = w;
    e.data = w ? v1 : v0;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (w) begin
      req1  = 1'b0;
      hold1 = 1'b0;
      hold0 = r0;
    end else begin
      req0  = 1'b0;
      hold0 = 1'b0;
      hold1 = r1;
    end
  endtask

  task automatic wait_idle(input bit noise);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (!busy) break;
      if (n > 20) begin
        chk("idle_timeout", busy, 0);
        break;
      end
      if (noise) begin
        if (!hold0) begin
          req0  = 1'($urandom_range(0, 1));
          data0 = W'($urandom);
        end
        if (!hold1) begin
          req1  = 1'($urandom_range(0, 1));
          data1 = W'($urandom);
        end
      end
    end
    if (!hold0) req0 = 1'b0;
    if (!hold1) req1 = 1'b0;
  endtask

  task automatic drain();
    while (hold0 || hold1) begin
      start_txn(hold0, hold1, data0, data1);
      wait_idle(1'b0);
    end
  endtask

  task automatic chk_zero(input string n);
    chk(n, {gnt0, gnt1, sr_load, sr_shift, sr_data_in,
            ser_bit, bit_valid, busy, done, done_id}, 0);
  endtask

  // Monitor: pops an expected transaction at each grant and checks the bit stream.
  initial begin
    act       = 1'b0;
    post_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        act       = 1'b0;
        post_done = 1'b0;
        continue;
      end
      chk("load_shift_overlap", sr_load & sr_shift, 0);
      if (post_done) begin
        chk("busy_after_done", busy, 0);
        post_done = 1'b0;
      end
      if (gnt0 || gnt1) begin
        if (q.size() == 0) begin
          chk("unexpected_gnt", {gnt0, gnt1}, 0);
        end else begin
          cur = q.pop_front();
          chk("gnt_id", {gnt0, gnt1}, cur.id ? 2'b01 : 2'b10);
          chk("load_cycle", {sr_load, sr_shift, busy}, 3'b101);
          chk("sr_data_in", sr_data_in, cur.data);
        end
        act  = 1'b1;
        nsh  = 0;
        nb   = 0;
        bits = '0;
      end else if (act) begin
        chk("busy_in_txn", busy, 1);
        if (sr_shift) nsh++;
        if (bit_valid) begin
          if (nb < W) bits[nb] = ser_bit;
          nb++;
        end
        if (done) begin
          chk("shift_cycles", nsh, 4);
          chk("bit_count", nb, 4);
          chk("ser_bits", bits, cur.data);
          chk("done_id", done_id, cur.id);
          act       = 1'b0;
          post_done = 1'b1;
        end
      end else begin
        chk("idle_quiet", {done, bit_valid, sr_shift, sr_load}, 0);
      end
    end
  end

  initial begin
    rst     = 1'b0;
    req0    = 1'b0;
    req1    = 1'b0;
    data0   = '0;
    data1   = '0;
    b_req0  = 1'b0;
    b_req1  = 1'b0;
    b_data0 = '0;
    b_data1 = '0;
    hold0   = 1'b0;
    hold1   = 1'b0;
    mlast   = 1'b1;

    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    rst = 1'b1;
    @(negedge clk);
    chk_zero("idle_outputs");

    // Two-shift instance, requester 1 with 0110.
    b_req1  = 1'b1;
    b_data1 = 4'b0110;
    @(posedge clk);
    @(negedge clk);
    chk("u2_gnt1", {b_gnt0, b_gnt1}, 2'b01);
    chk("u2_load", {b_load, b_din}, {1'b1, 4'b0110});
    b_req1 = 1'b0;
    ns2   = 0;
    nb2   = 0;
    seen2 = 1'b0;
    bb2   = '0;
    for (int i = 0; i < 10 && !seen2; i++) begin
      @(negedge clk);
      if (b_shift) ns2++;
      if (b_bv) begin
        if (nb2 < 2) bb2[nb2] = b_ser;
        nb2++;
      end
      if (b_done) begin
        seen2 = 1'b1;
        chk("u2_shift_cycles", ns2, 2);
        chk("u2_bit_count", nb2, 2);
        chk("u2_bits", bb2, 2'b10);
        chk("u2_done_id", b_done_id, 1);
      end
    end
    if (!seen2) chk("u2_done_timeout", seen2, 1);
    @(negedge clk);
    chk("u2_busy_after", b_busy, 0);

    // Tie from reset, then the held loser is served.
    start_txn(1'b1, 1'b1, 4'b0001, 4'b1000);
    wait_idle(1'b0);
    drain();

    // Single requester 0 with 1011.
    start_txn(1'b1, 1'b0, 4'b1011, 4'b0000);
    wait_idle(1'b0);

    // Both held: grants must alternate.
    for (int i = 0; i < 4; i++) begin
      start_txn(1'b1, 1'b1, W'($urandom), W'($urandom));
      wait_idle(1'b1);
    end
    drain();

    for (int i = 0; i < 30; i++) begin
      bit r0, r1;
      r0 = hold0 | 1'($urandom_range(0, 1));
      r1 = hold1 | 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      start_txn(r0, r1, hold0 ? data0 : W'($urandom), hold1 ? data1 : W'($urandom));
      wait_idle(1'b1);
    end
    drain();

    // Short req0 pulse while busy must be forgotten.
    start_txn(1'b1, 1'b0, W'($urandom), 4'b0000);
    @(negedge clk);
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    wait_idle(1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("pulse_no_grant", {gnt0, gnt1, busy}, 0);
    end

    // Abort a requester-1 transaction in its second shift cycle.
    start_txn(1'b0, 1'b1, 4'b0000, W'($urandom));
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_zero("abort_outputs");
    void'(q.size());
    mlast = 1'b1;
    hold0 = 1'b0;
    hold1 = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("abort_held");
    rst = 1'b1;
    start_txn(1'b1, 1'b1, W'($urandom), W'($urandom));
    wait_idle(1'b0);
    drain();

    repeat (5) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    chk("sb_idle", act, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=finish", checks);
    $fatal(1, "timeout");
  end

endmodule
